// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 set-2 make/break/E0/E1 decoder with held-key vector and optional event FIFO (PS2_EVENT_FIFO_EN)
module ps2_scancode_decoder #(
  parameter int NUM_KEYS = 10,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h05A, 9'h029, 9'h174, 9'h172, 9'h16B, 9'h175, 9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit REPORT_REPEAT = 1'b0,
  parameter int FIFO_DEPTH = 8,
  localparam int KIW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                ev_valid,
  output logic [KIW:0]        ev_data,
  input  logic                ev_ready,
  output logic                ev_overflow
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t state, state_nxt;
  logic [2:0] skip, skip_nxt;
  logic [TW-1:0] tcnt;
  logic dec, make, ext, clr, hit, push;
  logic [KIW-1:0] idx;
  logic [NUM_KEYS-1:0] key_nxt;
  logic [KIW:0] ev_in;

  always_comb begin
    state_nxt = state;
    skip_nxt = skip;
    dec = 1'b0;
    make = 1'b1;
    ext = 1'b0;
    clr = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          state_nxt = rx_data == 8'hE0 ? EXT : rx_data == 8'hF0 ? BRK : rx_data == 8'hE1 ? PAUSE : IDLE;
          skip_nxt = 3'd7;
          clr = rx_data inside {8'h00, 8'hFF};
          dec = !(rx_data inside {8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE});
        end
        EXT: begin
          state_nxt = rx_data == 8'hF0 ? EXT_BRK : IDLE;
          dec = rx_data != 8'hF0;
          ext = 1'b1;
        end
        BRK: begin
          state_nxt = IDLE;
          dec = 1'b1;
          make = 1'b0;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          dec = 1'b1;
          make = 1'b0;
          ext = 1'b1;
        end
        default: begin
          skip_nxt = skip - 3'd1;
          state_nxt = skip == 3'd1 ? IDLE : PAUSE;
        end
      endcase
    end else if (state != IDLE && tcnt == TMAX) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (KEY_CODES[9*i +: 9] == {ext, rx_data}) begin
        hit = 1'b1;
        idx = KIW'(i);
      end
  end

  assign push = dec && hit && (make ? !key_state[idx] || REPORT_REPEAT : key_state[idx]);
  assign ev_in = {make, idx};

  always_comb begin
    key_nxt = key_state;
    if (dec && hit) key_nxt[idx] = make;
    if (clr) key_nxt = '0;
  end

  always_ff @(posedge CLOCK)
    if (reset) begin
      state <= IDLE;
      skip <= '0;
      tcnt <= '0;
      key_state <= '0;
    end else begin
      state <= state_nxt;
      skip <= skip_nxt;
      tcnt <= rx_valid ? '0 : tcnt == TMAX ? tcnt : tcnt + 1'b1;
      key_state <= key_nxt;
    end

`ifdef PS2_EVENT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [KIW:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic pop, wen;

  assign ev_valid = cnt != '0;
  assign pop = ev_valid && ev_ready;
  assign wen = push && (cnt != (AW+1)'(FIFO_DEPTH) || pop);
  assign ev_data = ev_valid ? mem[rd] : '0;

  always_ff @(posedge CLOCK)
    if (wen) mem[wr] <= ev_in;

  always_ff @(posedge CLOCK)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      ev_overflow <= 1'b0;
    end else begin
      wr <= wr + AW'(wen);
      rd <= rd + AW'(pop);
      cnt <= cnt + (AW+1)'(wen) - (AW+1)'(pop);
      ev_overflow <= ev_overflow || (push && !wen);
    end
`else
  logic unused_fifo;
  assign unused_fifo = ^{ev_ready, push, ev_in};
  assign ev_valid = 1'b0;
  assign ev_data = '0;
  assign ev_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: table-driven key_state checks plus event scoreboard for two repeat settings
module tb_ps2_scancode_decoder;
  localparam int T = 40;
  typedef struct {logic [7:0] b; logic [9:0] ks; int e0; int e1;} vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic ev_ready = 1'b1;
  logic [7:0] rx_data = '0;
  logic [9:0] ks0, ks1;
  logic evv0, evv1, ovf0, ovf1;
  logic [4:0] evd0, evd1;
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  vec_t vt[$];
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .REPORT_REPEAT(1'b0)) r0 (
    .CLOCK(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .key_state(ks0),
    .ev_valid(evv0), .ev_data(evd0), .ev_ready(ev_ready), .ev_overflow(ovf0));

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .REPORT_REPEAT(1'b1)) r1 (
    .CLOCK(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .key_state(ks1),
    .ev_valid(evv1), .ev_data(evd1), .ev_ready(ev_ready), .ev_overflow(ovf1));

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic v(input logic [7:0] b, input logic [9:0] ks, input int e0, input int e1);
    vt.push_back('{b, ks, e0, e1});
  endtask

  task automatic exp_ev(input int e0, input int e1);
`ifdef PS2_EVENT_FIFO_EN
    if (e0 >= 0) q0.push_back(5'(e0));
    if (e1 >= 0) q1.push_back(5'(e1));
`endif
  endtask

  task automatic send(input logic [7:0] b, input int e);
    @(negedge clk);
    exp_ev(e, e);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ks_chk(input string n, input logic [9:0] e);
    chk(n, ks0, e);
    chk({n, "_rep"}, ks1, e);
  endtask

  task automatic drain(input string n);
    ev_ready = 1'b1;
    for (int i = 0; i < 40 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({n, "_q0_left"}, q0.size(), 0);
    chk({n, "_q1_left"}, q1.size(), 0);
    chk({n, "_ev_valid"}, {evv0, evv1}, 2'b00);
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (evv0 && ev_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL ev_r0: got %0h expected none", evd0);
      end else chk("ev_r0", evd0, q0.pop_front());
    end
    if (evv1 && ev_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL ev_r1: got %0h expected none", evd1);
      end else chk("ev_r1", evd1, q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    v(8'h1D, 10'h001, 'h10, 'h10);
    v(8'hF0, 10'h001, -1, -1);
    v(8'h1D, 10'h000, 'h00, 'h00);
    v(8'hE0, 10'h000, -1, -1);
    v(8'h75, 10'h010, 'h14, 'h14);
    v(8'h75, 10'h010, -1, -1);
    v(8'hF0, 10'h010, -1, -1);
    v(8'h75, 10'h010, -1, -1);
    v(8'hE0, 10'h010, -1, -1);
    v(8'hF0, 10'h010, -1, -1);
    v(8'h75, 10'h000, 'h04, 'h04);
    v(8'h29, 10'h100, 'h18, 'h18);
    v(8'h29, 10'h100, -1, 'h18);
    v(8'h29, 10'h100, -1, 'h18);
    v(8'hF0, 10'h100, -1, -1);
    v(8'h29, 10'h000, 'h08, 'h08);
    v(8'hE0, 10'h000, -1, -1);
    v(8'hE0, 10'h000, -1, -1);
    v(8'h6B, 10'h000, -1, -1);
    v(8'hE0, 10'h000, -1, -1);
    v(8'h6B, 10'h020, 'h15, 'h15);
    v(8'hAA, 10'h020, -1, -1);
    v(8'hFA, 10'h020, -1, -1);
    v(8'hEE, 10'h020, -1, -1);
    v(8'hFE, 10'h020, -1, -1);
    v(8'h1C, 10'h022, 'h11, 'h11);
    v(8'h23, 10'h02A, 'h13, 'h13);
    v(8'hF0, 10'h02A, -1, -1);
    v(8'h1C, 10'h028, 'h01, 'h01);
    v(8'h00, 10'h000, -1, -1);
    v(8'hE0, 10'h000, -1, -1);
    v(8'h1D, 10'h000, -1, -1);
    v(8'hE1, 10'h000, -1, -1);
    v(8'h14, 10'h000, -1, -1);
    v(8'h77, 10'h000, -1, -1);
    v(8'hE1, 10'h000, -1, -1);
    v(8'hF0, 10'h000, -1, -1);
    v(8'h14, 10'h000, -1, -1);
    v(8'hF0, 10'h000, -1, -1);
    v(8'h77, 10'h000, -1, -1);
    v(8'h1C, 10'h002, 'h11, 'h11);
    v(8'h5A, 10'h202, 'h19, 'h19);
    v(8'hF0, 10'h202, -1, -1);
    v(8'h5A, 10'h002, 'h09, 'h09);
    v(8'hFF, 10'h000, -1, -1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ks_chk("reset_ks", 10'h000);
    chk("reset_ev_valid", {evv0, evv1}, 2'b00);
    chk("reset_ev_data", {evd0, evd1}, 10'h000);
    chk("reset_overflow", {ovf0, ovf1}, 2'b00);
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      if (i > 0) ks_chk($sformatf("vec%0d", i - 1), vt[i-1].ks);
      exp_ev(vt[i].e0, vt[i].e1);
      rx_data = vt[i].b;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    ks_chk($sformatf("vec%0d", vt.size() - 1), vt[vt.size()-1].ks);
    rx_valid = 1'b0;
    drain("table");
    ev_ready = 1'b0;
    send(8'h1D, 'h10);
    send(8'h1C, 'h11);
    send(8'h1B, 'h12);
    send(8'h23, 'h13);
    send(8'hE0, -1);
    send(8'h75, 'h14);
    send(8'hE0, -1);
    send(8'h6B, 'h15);
    send(8'hE0, -1);
    send(8'h72, 'h16);
    send(8'hE0, -1);
    send(8'h74, 'h17);
    ks_chk("fill8_ks", 10'h0FF);
`ifdef PS2_EVENT_FIFO_EN
    chk("fill8_overflow", {ovf0, ovf1}, 2'b00);
    chk("fill8_valid", {evv0, evv1}, 2'b11);
    chk("fill8_head", evd0, 5'h10);
`else
    chk("nofifo_outputs", {evv0, evv1, ovf0, ovf1, evd0, evd1}, 14'h0);
`endif
    @(negedge clk);
    exp_ev('h18, 'h18);
    rx_data = 8'h29;
    rx_valid = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    ks_chk("full_pushpop_ks", 10'h1FF);
    chk("full_pushpop_overflow", {ovf0, ovf1}, 2'b00);
    drain("fill8");
    ev_ready = 1'b0;
    send(8'hF0, -1);
    send(8'h1D, 'h00);
    send(8'hF0, -1);
    send(8'h1C, 'h01);
    send(8'hF0, -1);
    send(8'h1B, 'h02);
    send(8'hF0, -1);
    send(8'h23, 'h03);
    send(8'hE0, -1);
    send(8'hF0, -1);
    send(8'h75, 'h04);
    send(8'hE0, -1);
    send(8'hF0, -1);
    send(8'h6B, 'h05);
    send(8'hE0, -1);
    send(8'hF0, -1);
    send(8'h72, 'h06);
    send(8'hE0, -1);
    send(8'hF0, -1);
    send(8'h74, 'h07);
    send(8'hF0, -1);
    send(8'h29, -1);
    ks_chk("release_ks", 10'h000);
`ifdef PS2_EVENT_FIFO_EN
    chk("overflow_sticky", {ovf0, ovf1}, 2'b11);
    chk("overflow_head", evd1, 5'h00);
`else
    chk("nofifo_overflow", {ovf0, ovf1}, 2'b00);
`endif
    drain("overflow");
    ev_ready = 1'b0;
    send(8'hE0, -1);
    send(8'h75, 'h14);
    ks_chk("up_held", 10'h010);
    send(8'hE0, -1);
    send(8'hF0, -1);
    @(negedge clk);
    reset = 1'b1;
    rx_data = 8'h1D;
    rx_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    q0.delete();
    q1.delete();
    ks_chk("midseq_reset_ks", 10'h000);
    chk("midseq_reset_ev_valid", {evv0, evv1}, 2'b00);
    chk("midseq_reset_ev_data", {evd0, evd1}, 10'h000);
    chk("midseq_reset_overflow", {ovf0, ovf1}, 2'b00);
    send(8'h75, -1);
    ks_chk("after_reset_75", 10'h000);
    drain("reset");
    send(8'h23, 'h13);
    ks_chk("to_hold", 10'h008);
    send(8'hF0, -1);
    idle(T - 3);
    send(8'h23, 'h03);
    ks_chk("to_before_expiry", 10'h000);
    send(8'hF0, -1);
    idle(T - 1);
    send(8'h23, 'h13);
    ks_chk("to_expired_brk", 10'h008);
    send(8'hF0, -1);
    send(8'h23, 'h03);
    ks_chk("to_release", 10'h000);
    send(8'hE0, -1);
    idle(T - 1);
    send(8'h75, -1);
    ks_chk("to_expired_ext", 10'h000);
    drain("timeout");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Parametrised PS/2 set-2 scancode decoder between the byte-level PS/2 receiver and game logic. It consumes received bytes as single-cycle strobes in the system clock domain and resolves make, break (F0), extended (E0) and Pause (E1) sequences with an explicit state machine. It maintains a held-key vector for a configurable key map. Optionally it queues make/break events in a small FIFO for consumers that must not miss short key taps.

## Interface

- NUM_KEYS, 10, number of mapped keys (1..64).
- KEY_CODES, {W,A,S,D,up,left,down,right,space,enter}, NUM_KEYS×9 packed bits; entry i at [9i+8:9i] = {ext, code}. Default entries, index 0 to 9: 0_1D, 0_1C, 0_1B, 0_23, 1_75, 1_6B, 1_72, 1_74, 0_29, 0_5A.
- TIMEOUT_CYCLES, 100000, idle cycles after which a partial sequence is abandoned (2 ms at 50 MHz).
- REPORT_REPEAT, 0, 1 = typematic repeats of a held key also generate make events.
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2).
- CLOCK, input, 1, system clock; every register on posedge.
- reset, input, 1, synchronous, active-high.
- rx_data, input, 8, received byte; valid only while rx_valid=1.
- rx_valid, input, 1, one-cycle strobe per received byte, synchronous to CLOCK.
- key_state, output, NUM_KEYS, bit i = 1 while key i is held.
- ev_valid, output, 1, event FIFO non-empty.
- ev_data, output, 1+KIW, {make=1/break=0, key index}; KIW = max(1,$clog2(NUM_KEYS)); show-ahead.
- ev_ready, input, 1, pop the head when ev_valid=1.
- ev_overflow, output, 1, sticky; an event was dropped because the FIFO was full.

## Operation

- Reset: state=IDLE, key_state=0, FIFO empty, ev_valid=0, ev_data=0, ev_overflow=0, timeout counter=0.
- States: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on rx_valid.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE with skip=7.
  - 00 or FF (overrun/error) → key_state cleared, no events.
  - AA, FA, EE, FE ignored.
  - Any other byte is a make with ext=0.
- EXT: F0 → EXT_BRK; any other byte is a make with ext=1, then → IDLE. An E0 here (fake-shift padding) is a make with ext=1 and code E0; it is normally unmapped.
- BRK: byte is a break with ext=0, then → IDLE.
- EXT_BRK: byte is a break with ext=1, then → IDLE.
- PAUSE: each byte decrements skip; → IDLE when skip reaches 0. Bytes are not decoded.
- Lookup: {ext, byte} is compared with all KEY_CODES entries. The lowest matching index wins. No match → no effect, no event.
- Make of key i:
  - If key_state[i]=0: set the bit and push {1,i}.
  - If already set: push {1,i} only when REPORT_REPEAT=1.
- Break of key i: clear the bit. Push {0,i} only if the bit was set.
- Timeout: the counter clears on every rx_valid and counts otherwise, saturating. If state≠IDLE and the counter reaches TIMEOUT_CYCLES-1, state → IDLE. key_state is unchanged.
- FIFO:
  - Pop when ev_valid & ev_ready.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - A rejected push sets ev_overflow; the FIFO contents are unchanged.
  - ev_ready while empty has no effect.
- Every decode step produces at most one push.

## Timing

- rx_valid at cycle t → key_state updated at t+1.
- Push at t → ev_valid=1 at t+1 if the FIFO was empty. ev_data is stable while ev_valid=1 and ev_ready=0.
- Back-to-back rx_valid on consecutive cycles is fully supported; no stall.
- Pop and push in the same cycle: occupancy is unchanged, and the head advances to the next entry (or to the new entry if it was the only one).
- reset asserted mid-sequence or with the FIFO non-empty: everything returns to reset values at the next edge. Bytes arriving while reset=1 are discarded.

## Configuration

- PS2_EVENT_FIFO_EN defined: FIFO, ev_valid, ev_data, ev_overflow behave as above.
- PS2_EVENT_FIFO_EN not defined:
  - No FIFO storage is built; ev_valid, ev_data and ev_overflow are tied to 0; ev_ready is ignored.
  - key_state behaviour is identical in both cases.

## Test plan

- Press/release W: bytes 1D, F0, 1D.
  - key_state[0]=1 one cycle after 1D and back to 0 after the final 1D.
  - Events {1,0} then {0,0}.
- Extended keys:
  - E0 75 → key_state[4]=1.
  - E0 F0 75 → key_state[4]=0.
  - Plain 75 (no E0) must not touch key_state[4].
- Repeat, REPORT_REPEAT=0 versus 1: 29 29 29 F0 29.
  - With 0: events {1,8},{0,8}.
  - With 1: events {1,8},{1,8},{1,8},{0,8}.
- Pause and timeout:
  - E1 14 77 E1 F0 14 F0 77 followed by 1C → no change from the Pause bytes, key_state[1]=1.
  - F0, then TIMEOUT_CYCLES idle cycles, then 23 → key_state[3]=1 (treated as a make).
- FIFO full, FIFO_DEPTH=8, ev_ready=0: 9 distinct make events.
  - First 8 are retained and ev_overflow=1.
  - After draining, events come out in order, then ev_valid=0.
- Error and reset:
  - 00 received while keys are held → key_state=0.
  - reset asserted after E0 F0 → the next byte 75 is a make with ext=0 (unmapped), and key_state stays 0.
